// File: rtl/ma_burst_ctrl.sv
// Memory-access burst controller: resolves an ARF-relative byte address, then
// sequences one (vector) or MAT_ROWS (matrix) beat requests across DDR4 channels.
module ma_burst_ctrl #(
  parameter int NUM_OF_DDR4     = 2,
  parameter int DDR4_ADDRWIDTH  = 28,
  parameter int ARF_ADDRWIDTH   = 5,
  parameter int ARF_DATAWIDTH   = 32,
  parameter int VRF_ADDRWIDTH   = 5,
  parameter int MAT_ROWS        = 4,
  parameter int BEAT_BYTES      = 64,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CHW = (NUM_OF_DDR4 > 1) ? $clog2(NUM_OF_DDR4) : 1,
  localparam int RW  = $clog2(MAT_ROWS),
  localparam int BB  = $clog2(BEAT_BYTES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_OF_DDR4-1:0]    ma_ddr4_calib_complete_i,
  output logic                      ma_ddr4_linkup_o,
  input  logic                      ma_start_i,
  input  logic                      ma_select_v_m_i,
  input  logic                      ma_v_load_or_store_i,
  input  logic [VRF_ADDRWIDTH-1:0]  ma_v_m_reg_i,
  input  logic [ARF_ADDRWIDTH-1:0]  ma_a_reg_i,
  input  logic [15:0]               ma_a_offset_i,
  output logic                      ma_busy_o,
  output logic                      ma_done_o,
  output logic                      ma_err_o,
  output logic                      arf_en_o,
  output logic                      arf_we_o,
  output logic [ARF_ADDRWIDTH-1:0]  arf_addr_o,
  input  logic [ARF_DATAWIDTH-1:0]  arf_dout_i,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic [CHW-1:0]            mem_req_ch_o,
  output logic                      mem_req_we_o,
  output logic [DDR4_ADDRWIDTH-1:0] mem_req_addr_o,
  output logic [VRF_ADDRWIDTH-1:0]  mem_req_reg_o,
  output logic [RW-1:0]             mem_req_row_o,
  input  logic                      mem_rsp_valid_i,
  output logic [2:0]                dbg_state
);

  localparam int AW = DDR4_ADDRWIDTH;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARF_RD   = 3'd1,
    S_CALC     = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_RSP = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                   state;
  logic                     mode_q;
  logic                     dir_q;
  logic [VRF_ADDRWIDTH-1:0] vreg_q;
  logic [15:0]              off_q;
  logic                     abort_q;
  logic [OW-1:0]            outstanding;
  logic [OW-1:0]            out_next;

  logic          link_next;
  logic          hs;
  logic          rsp_take;
  logic          room;
  logic          beat_last;
  logic          misaligned;
  logic [AW-1:0] base;
  logic [AW-1:0] off_ext;
  logic [AW-1:0] ea;
  logic [AW-1:0] addr_inc;

  function automatic logic [CHW-1:0] ch_of(input logic [AW-1:0] a);
    logic [AW-1:0] beat_idx;
    beat_idx = a >> BB;
    return CHW'(beat_idx % AW'(NUM_OF_DDR4));
  endfunction

  assign arf_we_o  = 1'b0;
  assign dbg_state = state;
  assign link_next = &ma_ddr4_calib_complete_i;

  // Request channel: a beat transfers on any cycle where valid and ready are both
  // high; valid never drops and no field changes until that transfer happens,
  // except on link loss, which withdraws the request.
  assign hs       = mem_req_valid_o & mem_req_ready_i;
  assign rsp_take = mem_rsp_valid_i && (outstanding != '0);

  always_comb begin
    out_next = outstanding;
    if (hs)       out_next = out_next + 1'b1;
    if (rsp_take) out_next = out_next - 1'b1;
  end

  assign room       = out_next < OW'(MAX_OUTSTANDING);
  assign beat_last  = !mode_q || (mem_req_row_o == RW'(MAT_ROWS - 1));
  assign base       = AW'(arf_dout_i);
  assign off_ext    = AW'($signed(off_q));
  assign ea         = base + off_ext;
  assign misaligned = |ea[BB-1:0];
  assign addr_inc   = mem_req_addr_o + AW'(BEAT_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      ma_ddr4_linkup_o <= 1'b0;
      ma_busy_o        <= 1'b0;
      ma_done_o        <= 1'b0;
      ma_err_o         <= 1'b0;
      arf_en_o         <= 1'b0;
      arf_addr_o       <= '0;
      mem_req_valid_o  <= 1'b0;
      mem_req_ch_o     <= '0;
      mem_req_we_o     <= 1'b0;
      mem_req_addr_o   <= '0;
      mem_req_reg_o    <= '0;
      mem_req_row_o    <= '0;
      outstanding      <= '0;
      mode_q           <= 1'b0;
      dir_q            <= 1'b0;
      vreg_q           <= '0;
      off_q            <= '0;
      abort_q          <= 1'b0;
    end else begin
      ma_ddr4_linkup_o <= link_next;
      outstanding      <= out_next;
      ma_done_o        <= 1'b0;
      ma_err_o         <= 1'b0;
      arf_en_o         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ma_start_i && ma_ddr4_linkup_o) begin
            mode_q     <= ma_select_v_m_i;
            dir_q      <= ma_v_load_or_store_i;
            vreg_q     <= ma_v_m_reg_i;
            off_q      <= ma_a_offset_i;
            abort_q    <= 1'b0;
            ma_busy_o  <= 1'b1;
            arf_en_o   <= 1'b1;
            arf_addr_o <= ma_a_reg_i;
            state      <= S_ARF_RD;
          end
        end
        S_ARF_RD: begin
          if (!link_next) begin
            abort_q <= 1'b1;
            state   <= S_WAIT_RSP;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (!link_next) begin
            abort_q <= 1'b1;
            state   <= S_WAIT_RSP;
          end else if (misaligned) begin
            ma_done_o <= 1'b1;
            ma_err_o  <= 1'b1;
            state     <= S_DONE;
          end else begin
            mem_req_addr_o  <= ea;
            mem_req_ch_o    <= ch_of(ea);
            mem_req_row_o   <= '0;
            mem_req_we_o    <= dir_q;
            mem_req_reg_o   <= vreg_q;
            mem_req_valid_o <= room;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!link_next) begin
            // Beats already handed over still complete; drain them in WAIT_RSP.
            mem_req_valid_o <= 1'b0;
            abort_q         <= 1'b1;
            state           <= S_WAIT_RSP;
          end else if (hs && beat_last) begin
            mem_req_valid_o <= 1'b0;
            state           <= S_WAIT_RSP;
          end else begin
            if (hs) begin
              mem_req_addr_o <= addr_inc;
              mem_req_ch_o   <= ch_of(addr_inc);
              mem_req_row_o  <= mem_req_row_o + 1'b1;
            end
            mem_req_valid_o <= room;
          end
        end
        S_WAIT_RSP: begin
          if (!link_next) abort_q <= 1'b1;
          if (out_next == '0) begin
            ma_done_o <= 1'b1;
            ma_err_o  <= abort_q | !link_next;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          ma_busy_o <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_burst_ctrl.sv
// Directed bench for ma_burst_ctrl: table of command/handshake scripts with
// hand-computed beat fields and done timing, plus linkup and reset sequences.
module tb_ma_burst_ctrl;

  localparam int W = 31;  // {ch, row[1:0], addr[27:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  calib;
  logic        linkup;
  logic        start;
  logic        sel_vm;
  logic        dir;
  logic [4:0]  vreg;
  logic [4:0]  areg;
  logic [15:0] off;
  logic        busy, done, err;
  logic        arf_en, arf_we;
  logic [4:0]  arf_addr;
  logic [31:0] arf_dout;
  logic        valid, ready;
  logic        ch, we;
  logic [27:0] addr;
  logic [4:0]  rreg;
  logic [1:0]  row;
  logic        rsp;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ma_burst_ctrl #(
    .NUM_OF_DDR4(2), .DDR4_ADDRWIDTH(28), .ARF_ADDRWIDTH(5), .ARF_DATAWIDTH(32),
    .VRF_ADDRWIDTH(5), .MAT_ROWS(4), .BEAT_BYTES(64), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk), .rst(rst),
    .ma_ddr4_calib_complete_i(calib), .ma_ddr4_linkup_o(linkup),
    .ma_start_i(start), .ma_select_v_m_i(sel_vm), .ma_v_load_or_store_i(dir),
    .ma_v_m_reg_i(vreg), .ma_a_reg_i(areg), .ma_a_offset_i(off),
    .ma_busy_o(busy), .ma_done_o(done), .ma_err_o(err),
    .arf_en_o(arf_en), .arf_we_o(arf_we), .arf_addr_o(arf_addr), .arf_dout_i(arf_dout),
    .mem_req_valid_o(valid), .mem_req_ready_i(ready),
    .mem_req_ch_o(ch), .mem_req_we_o(we), .mem_req_addr_o(addr),
    .mem_req_reg_o(rreg), .mem_req_row_o(row), .mem_rsp_valid_i(rsp),
    .dbg_state(dbg_state)
  );

  // ARF model: synchronous read, one-cycle latency
  logic [31:0] arf_mem [32];
  initial arf_dout = '0;
  always @(posedge clk) if (arf_en) arf_dout <= arf_mem[arf_addr];

  typedef struct packed {
    logic            mode;
    logic            dir;
    logic [4:0]      vreg;
    logic [4:0]      areg;
    logic [31:0]     arf_val;
    logic [15:0]     off;
    logic [31:0]     ready_mask;  // bit c = ready during cycle c
    logic [31:0]     rsp_mask;    // bit c = rsp during cycle c
    logic [7:0]      drop_cyc;    // calib drops from this cycle (0 = never)
    logic [2:0]      n_beats;     // handshakes expected
    logic [7:0]      done_cyc;
    logic            err;
    logic [3:0][27:0] addr;
    logic [3:0]      ch;
  } vec_t;

  vec_t vecs[8];
  logic [W-1:0] exp_q[$];

  function automatic vec_t mk(input logic m, input logic d, input logic [4:0] vr,
                              input logic [4:0] ar, input logic [31:0] av, input logic [15:0] o,
                              input logic [31:0] rdy, input logic [31:0] rs, input int drop,
                              input int nb, input int dc, input logic e,
                              input logic [27:0] a0, input logic [27:0] a1,
                              input logic [27:0] a2, input logic [27:0] a3, input logic [3:0] c);
    vec_t v;
    v.mode = m; v.dir = d; v.vreg = vr; v.areg = ar; v.arf_val = av; v.off = o;
    v.ready_mask = rdy; v.rsp_mask = rs; v.drop_cyc = 8'(drop); v.n_beats = 3'(nb);
    v.done_cyc = 8'(dc); v.err = e; v.addr = {a3, a2, a1, a0}; v.ch = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   hs_cnt;
    int   nexp;
    int   k;
    bit   seen_done;
    v = vecs[idx];
    calib = 2'b11;
    k = 0;
    while (!linkup && k < 5) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("v%0d_linkup", idx), 32'(linkup), 32'd1);
    arf_mem[v.areg] = v.arf_val;
    exp_q.delete();
    nexp = v.mode ? 4 : 1;
    for (int b = 0; b < nexp; b++) exp_q.push_back({v.ch[b], 2'(b), v.addr[b]});
    start = 1'b1; sel_vm = v.mode; dir = v.dir; vreg = v.vreg; areg = v.areg; off = v.off;
    hs_cnt = 0;
    seen_done = 1'b0;
    for (int cyc = 1; cyc <= 31; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      ready = v.ready_mask[cyc];
      rsp   = v.rsp_mask[cyc];
      calib = (v.drop_cyc != 0 && cyc >= int'(v.drop_cyc)) ? 2'b01 : 2'b11;
      if (cyc == 1)
        check($sformatf("v%0d_arf_rd", idx), {25'd0, arf_en, busy, arf_addr}, {25'd0, 2'b11, v.areg});
      if (valid) begin
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_extra_beat_c%0d", idx, cyc), 32'(valid), 32'd0);
        end else begin
          check($sformatf("v%0d_beat_c%0d", idx, cyc), 32'({ch, row, addr}), 32'(exp_q[0]));
          check($sformatf("v%0d_we_reg_c%0d", idx, cyc), 32'({we, rreg}), 32'({v.dir, v.vreg}));
          if (ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
      if (done) begin
        check($sformatf("v%0d_done_cycle", idx), 32'(cyc), 32'(v.done_cyc));
        check($sformatf("v%0d_err", idx), 32'(err), 32'(v.err));
        check($sformatf("v%0d_beats", idx), 32'(hs_cnt), 32'(v.n_beats));
        seen_done = 1'b1;
        break;
      end
    end
    if (!seen_done) check($sformatf("v%0d_done_timeout", idx), 32'd0, 32'd1);
    ready = 1'b0;
    rsp   = 1'b0;
    calib = 2'b11;
    @(negedge clk);
    check($sformatf("v%0d_idle_after", idx), {28'd0, busy, dbg_state}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(0, 0, 5'd2, 5'd4, 32'h0000_1000, 16'h0100, 32'hFFFF_FFFF, 32'h10, 0, 1, 5, 0,
                 28'h1100, 28'h0, 28'h0, 28'h0, 4'b0000);
    vecs[1] = mk(1, 1, 5'd7, 5'd3, 32'h0000_2000, 16'hFFC0, 32'hFFFF_FFFF, 32'hF0, 0, 4, 8, 0,
                 28'h1FC0, 28'h2000, 28'h2040, 28'h2080, 4'b0101);
    vecs[2] = mk(0, 0, 5'd2, 5'd4, 32'h0000_1000, 16'h0104, 32'hFFFF_FFFF, 32'h0, 0, 0, 3, 1,
                 28'h0, 28'h0, 28'h0, 28'h0, 4'b0000);
    vecs[3] = mk(1, 0, 5'd9, 5'd3, 32'h0000_2000, 16'hFFC0, 32'hFFFF_FF8F, 32'hE80, 0, 4, 12, 0,
                 28'h1FC0, 28'h2000, 28'h2040, 28'h2080, 4'b0101);
    vecs[4] = mk(1, 1, 5'd1, 5'd5, 32'h0000_4000, 16'h0000, 32'hFFFF_FFE8, 32'h40, 4, 1, 7, 1,
                 28'h4000, 28'h4040, 28'h4080, 28'h40C0, 4'b1010);
    vecs[5] = mk(1, 0, 5'd31, 5'd10, 32'hFFFF_FFC0, 16'h0000, 32'hFFFF_FFFF, 32'hF0, 0, 4, 8, 0,
                 28'hFFFFFC0, 28'h0000000, 28'h0000040, 28'h0000080, 4'b0101);
    vecs[6] = mk(0, 1, 5'd0, 5'd0, 32'h0000_0080, 16'hFFC0, 32'hFFFF_FFFF, 32'h10, 0, 1, 5, 0,
                 28'h0000040, 28'h0, 28'h0, 28'h0, 4'b0001);
    vecs[7] = mk(0, 0, 5'd12, 5'd20, 32'h0000_0000, 16'hFF80, 32'hFFFF_FFFF, 32'h10, 0, 1, 5, 0,
                 28'hFFFFF80, 28'h0, 28'h0, 28'h0, 4'b0000);

    for (int i = 0; i < 32; i++) arf_mem[i] = '0;
    rst = 1'b1; calib = 2'b00; start = 1'b0; sel_vm = 1'b0; dir = 1'b0;
    vreg = '0; areg = '0; off = '0; ready = 1'b0; rsp = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_ctrl", {23'd0, linkup, busy, done, err, arf_en, arf_we, valid, we, ch},
          32'd0);
    check("reset_req", {addr, row, 2'b00}, 32'd0);
    check("reset_misc", {19'd0, arf_addr, rreg, dbg_state}, 32'd0);

    // Partial calibration: linkup stays low and a start is ignored
    rst = 1'b0;
    calib = 2'b01;
    repeat (2) @(negedge clk);
    check("linkup_partial", 32'(linkup), 32'd0);
    arf_mem[4] = 32'h1000;
    start = 1'b1; sel_vm = 1'b0; areg = 5'd4; off = 16'h0100; vreg = 5'd2;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("ignored_start_c%0d", c), {28'd0, arf_en, busy, done, valid}, 32'd0);
    end
    calib = 2'b11;
    check("linkup_before_edge", 32'(linkup), 32'd0);
    @(negedge clk);
    check("linkup_after_edge", 32'(linkup), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset asserted while a matrix transfer is stalled in ISSUE
    arf_mem[3] = 32'h2000;
    ready = 1'b0;
    start = 1'b1; sel_vm = 1'b1; dir = 1'b0; areg = 5'd3; off = 16'h0000; vreg = 5'd6;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_valid", {30'd0, valid, busy}, 32'd3);
    rst = 1'b1;
    #1;
    check("async_reset_ctrl", {24'd0, linkup, busy, done, err, arf_en, valid, we, ch}, 32'd0);
    check("async_reset_req", {addr, row, 2'b00}, 32'd0);
    check("async_reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
